fpf_decoder_38: RTL and testbench

- Converts one 38-bit forbidden-pattern-free (FPF) crosstalk-avoidance codeword back to its binary value.
- Sits at the receive end of the FPF link, directly after the bus capture register. It is the inverse of the 38-bit FPF encoder.
- Multi-cycle, area-lean implementation: the codeword is latched, then BPC bits per cycle are accumulated MSB-first against the Fibonacci weight table.
- Valid/ready handshake on both sides.

---
 rtl/fpf_decoder_38_pkg.sv | 103 ++++++++++
 rtl/fpf_decoder_38_pattern_check.sv | 21 ++
 rtl/fpf_decoder_38.sv | 140 ++++++++++++++
 tb/tb_fpf_decoder_38.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpf_decoder_38_pkg.sv
// Shared constants for the 38-bit FPF decoder: Fibonacci weight table
// (FNS01..FNS39), decoded-value width, weight lookup and FSM encoding.
package fpf_decoder_38_pkg;

  localparam int FBLEN38 = 27;  // bits needed for the largest 38-bit FPF value
  localparam int FPF_CW  = 38;  // codeword width

  typedef logic [FBLEN38-1:0] fbval_t;

  localparam fbval_t FNS01 = 27'd1;
  localparam fbval_t FNS02 = 27'd1;
  localparam fbval_t FNS03 = 27'd2;
  localparam fbval_t FNS04 = 27'd3;
  localparam fbval_t FNS05 = 27'd5;
  localparam fbval_t FNS06 = 27'd8;
  localparam fbval_t FNS07 = 27'd13;
  localparam fbval_t FNS08 = 27'd21;
  localparam fbval_t FNS09 = 27'd34;
  localparam fbval_t FNS10 = 27'd55;
  localparam fbval_t FNS11 = 27'd89;
  localparam fbval_t FNS12 = 27'd144;
  localparam fbval_t FNS13 = 27'd233;
  localparam fbval_t FNS14 = 27'd377;
  localparam fbval_t FNS15 = 27'd610;
  localparam fbval_t FNS16 = 27'd987;
  localparam fbval_t FNS17 = 27'd1597;
  localparam fbval_t FNS18 = 27'd2584;
  localparam fbval_t FNS19 = 27'd4181;
  localparam fbval_t FNS20 = 27'd6765;
  localparam fbval_t FNS21 = 27'd10946;
  localparam fbval_t FNS22 = 27'd17711;
  localparam fbval_t FNS23 = 27'd28657;
  localparam fbval_t FNS24 = 27'd46368;
  localparam fbval_t FNS25 = 27'd75025;
  localparam fbval_t FNS26 = 27'd121393;
  localparam fbval_t FNS27 = 27'd196418;
  localparam fbval_t FNS28 = 27'd317811;
  localparam fbval_t FNS29 = 27'd514229;
  localparam fbval_t FNS30 = 27'd832040;
  localparam fbval_t FNS31 = 27'd1346269;
  localparam fbval_t FNS32 = 27'd2178309;
  localparam fbval_t FNS33 = 27'd3524578;
  localparam fbval_t FNS34 = 27'd5702887;
  localparam fbval_t FNS35 = 27'd9227465;
  localparam fbval_t FNS36 = 27'd14930352;
  localparam fbval_t FNS37 = 27'd24157817;
  localparam fbval_t FNS38 = 27'd39088169;
  localparam fbval_t FNS39 = 27'd63245986;

  // Weight of codeword bit 'index', i.e. FNS(index+1).
  function automatic fbval_t fns_weight(input logic [5:0] index);
    case (index)
      6'd0:  return FNS01;
      6'd1:  return FNS02;
      6'd2:  return FNS03;
      6'd3:  return FNS04;
      6'd4:  return FNS05;
      6'd5:  return FNS06;
      6'd6:  return FNS07;
      6'd7:  return FNS08;
      6'd8:  return FNS09;
      6'd9:  return FNS10;
      6'd10: return FNS11;
      6'd11: return FNS12;
      6'd12: return FNS13;
      6'd13: return FNS14;
      6'd14: return FNS15;
      6'd15: return FNS16;
      6'd16: return FNS17;
      6'd17: return FNS18;
      6'd18: return FNS19;
      6'd19: return FNS20;
      6'd20: return FNS21;
      6'd21: return FNS22;
      6'd22: return FNS23;
      6'd23: return FNS24;
      6'd24: return FNS25;
      6'd25: return FNS26;
      6'd26: return FNS27;
      6'd27: return FNS28;
      6'd28: return FNS29;
      6'd29: return FNS30;
      6'd30: return FNS31;
      6'd31: return FNS32;
      6'd32: return FNS33;
      6'd33: return FNS34;
      6'd34: return FNS35;
      6'd35: return FNS36;
      6'd36: return FNS37;
      6'd37: return FNS38;
      6'd38: return FNS39;
      default: return '0;
    endcase
  endfunction

  // FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fpf_decoder_38_pattern_check.sv
// Forbidden-pattern detector: flags any 3-bit window of the codeword
// equal to 010 or 101. Only instantiated when FPF_CHECK_EN is defined.
module fpf_pattern_check
  import fpf_decoder_38_pkg::*;
(
  input  logic [FPF_CW-1:0] i_code,
  output logic              o_err
);

  // Scan every 3-bit window for an isolated bit or an isolated hole
  always_comb begin
    // NOTE: default assigned first so every path drives o_err; no latch is inferred.
    o_err = 1'b0;
    for (int i = 0; i <= FPF_CW - 3; i++) begin
      if (i_code[i +: 3] == 3'b010 || i_code[i +: 3] == 3'b101) begin
        o_err = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpf_decoder_38.sv
// 38-bit FPF codeword to binary decoder. Latches the codeword, then sums
// BPC Fibonacci weights per cycle MSB-first; valid/ready on both sides.
// Optional forbidden-pattern flag (code_err) enabled by macro FPF_CHECK_EN.
module fpf_decoder_38
  import fpf_decoder_38_pkg::*;
#(
  parameter int BPC = 2,       // codeword bits consumed per accumulate cycle
  parameter int CW  = FPF_CW   // fixed codeword width
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [CW-1:0]      code_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [FBLEN38-1:0] data_out,
  output logic               out_valid,
  input  logic               out_ready
`ifdef FPF_CHECK_EN
  ,
  output logic               code_err
`endif
);

  localparam int N = CW / BPC;  // accumulate cycles per word

  // Reject unsupported configurations at elaboration
  if (!(BPC == 1 || BPC == 2 || BPC == 19 || BPC == 38)) begin : g_bad_bpc
    $error("fpf_decoder_38: BPC must be 1, 2, 19 or 38");
  end
  if (CW != FPF_CW || N * BPC != CW) begin : g_bad_cw
    $error("fpf_decoder_38: CW must be 38");
  end

  state_t       r_state;
  state_t       w_state_nxt;
  logic [CW-1:0] r_code;
  fbval_t       r_acc;
  fbval_t       r_data;
  logic [5:0]   r_idx;
  fbval_t       w_partial;
  logic         w_in_ready;
  logic         w_out_valid;
  logic         w_accept;
  logic         w_last;

  // Sum of the weights of the BPC set bits at idx..idx-BPC+1
  function automatic fbval_t partial_sum(input logic [CW-1:0] code,
                                         input logic [5:0]    idx);
    fbval_t     s;
    logic [5:0] b;
    s = '0;
    for (int j = 0; j < BPC; j++) begin
      b = idx - 6'(j);
      if (code[b]) s = s + fns_weight(b);
    end
    return s;
  endfunction

  assign w_partial = partial_sum(r_code, r_idx);
  assign w_accept  = in_valid && w_in_ready;
  assign w_last    = (r_state == ST_ACC) && (r_idx == 6'(BPC - 1));

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_ACC;
      end
      ST_ACC: begin
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Codeword latch, accumulator, bit index and result register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_code <= '0;
      r_acc  <= '0;
      r_idx  <= 6'(CW - 1);
      r_data <= '0;
    end else if (w_accept) begin
      r_code <= code_in;
      r_acc  <= '0;
      r_idx  <= 6'(CW - 1);
    end else if (r_state == ST_ACC) begin
      r_acc <= r_acc + w_partial;
      if (w_last) begin
        r_data <= r_acc + w_partial;
      end else begin
        r_idx <= r_idx - 6'(BPC);
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign data_out  = r_data;

`ifdef FPF_CHECK_EN
  logic w_chk_err;
  logic r_code_err;

  fpf_pattern_check u_check (
    .i_code (code_in),
    .o_err  (w_chk_err)
  );

  // Capture the pattern flag together with the codeword at accept
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_code_err <= 1'b0;
    end else if (w_accept) begin
      r_code_err <= w_chk_err;
    end
  end

  assign code_err = r_code_err;
`endif

endmodule

// File: tb/tb_fpf_decoder_38.sv
// Directed bench for fpf_decoder_38: reset values, decode values/latency,
// backpressure, reset mid-accumulate, back-to-back acceptance, BPC sweep,
// greedy-encode round trip and (with FPF_CHECK_EN) the pattern flag.
module tb_fpf_decoder_38;

  localparam int MAXV = 102334154;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [37:0] code_in;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] data_out;
  logic        out_valid;
  logic        out_ready;
  logic        sw_valid;
  logic        sw_rdy [3];
  logic [26:0] sw_data [3];
  logic        sw_ov [3];
`ifdef FPF_CHECK_EN
  logic        code_err;
  logic        sw_err [3];
  logic        last_err;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [26:0] fib [38];

  always #5 clock = ~clock;

  fpf_decoder_38 #(.BPC(2)) dut (
    .clock(clock), .reset_n(reset_n), .code_in(code_in), .in_valid(in_valid),
    .in_ready(in_ready), .data_out(data_out), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef FPF_CHECK_EN
    , .code_err(code_err)
`endif
  );

  fpf_decoder_38 #(.BPC(1)) u_b1 (
    .clock(clock), .reset_n(reset_n), .code_in(code_in), .in_valid(sw_valid),
    .in_ready(sw_rdy[0]), .data_out(sw_data[0]), .out_valid(sw_ov[0]),
    .out_ready(1'b1)
`ifdef FPF_CHECK_EN
    , .code_err(sw_err[0])
`endif
  );

  fpf_decoder_38 #(.BPC(19)) u_b19 (
    .clock(clock), .reset_n(reset_n), .code_in(code_in), .in_valid(sw_valid),
    .in_ready(sw_rdy[1]), .data_out(sw_data[1]), .out_valid(sw_ov[1]),
    .out_ready(1'b1)
`ifdef FPF_CHECK_EN
    , .code_err(sw_err[1])
`endif
  );

  fpf_decoder_38 #(.BPC(38)) u_b38 (
    .clock(clock), .reset_n(reset_n), .code_in(code_in), .in_valid(sw_valid),
    .in_ready(sw_rdy[2]), .data_out(sw_data[2]), .out_valid(sw_ov[2]),
    .out_ready(1'b1)
`ifdef FPF_CHECK_EN
    , .code_err(sw_err[2])
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Greedy Fibonacci encoding using the bench's own weight table
  function automatic logic [37:0] encode(input int unsigned v);
    logic [37:0] c;
    int unsigned r;
    c = '0;
    r = v;
    for (int k = 37; k >= 0; k--) begin
      if (r >= fib[k]) begin
        c[k] = 1'b1;
        r    = r - fib[k];
      end
    end
    return c;
  endfunction

  // Send one word to the BPC=2 decoder and check value, latency and busy
  task automatic run_word(input logic [37:0] code, input logic [26:0] exp, input string tag);
    int   lat;
    logic busy_ok;
    check({tag, "_rdy"}, in_ready, 1);
    code_in  = code;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    code_in  = ~code;
    lat      = 0;
    busy_ok  = 1'b1;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, 19);
    check({tag, "_busy"}, busy_ok, 1);
    check({tag, "_data"}, data_out, exp);
    check({tag, "_rdy_done"}, in_ready, 0);
`ifdef FPF_CHECK_EN
    last_err = code_err;
`endif
    if (out_ready) begin
      tick();
      check({tag, "_ov_clr"}, out_valid, 0);
      check({tag, "_rdy_back"}, in_ready, 1);
    end
  endtask

  // Send one word to the BPC=1/19/38 decoders at once
  task automatic sweep(input logic [37:0] code, input logic [26:0] exp, input string tag);
    int          lat [3];
    logic [26:0] dat [3];
    int          exp_lat [3];
    exp_lat = '{38, 2, 1};
    for (int d = 0; d < 3; d++) begin
      lat[d] = -1;
      dat[d] = '0;
      check($sformatf("%s_rdy%0d", tag, d), sw_rdy[d], 1);
    end
    code_in  = code;
    sw_valid = 1'b1;
    tick();
    sw_valid = 1'b0;
    for (int e = 1; e <= 45; e++) begin
      for (int d = 0; d < 3; d++) begin
        if (sw_ov[d] === 1'b1 && lat[d] < 0) begin
          lat[d] = e - 1;
          dat[d] = sw_data[d];
        end
      end
      tick();
    end
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_lat%0d", tag, d), lat[d], exp_lat[d]);
      check($sformatf("%s_data%0d", tag, d), dat[d], exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          edges;
    logic        acc_now;
    logic        seen;
    int unsigned v;

    fib[0] = 27'd1;
    fib[1] = 27'd1;
    for (int k = 2; k < 38; k++) fib[k] = fib[k-1] + fib[k-2];

    reset_n   = 1'b0;
    code_in   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sw_valid  = 1'b0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_data_out", data_out, 0);
    reset_n = 1'b1;
    tick();

    // Basic and boundary decodes
    run_word(38'h0, 27'd0, "zero");
    run_word(38'h1, 27'd1, "one");
    run_word(38'h7, 27'd4, "seven");
    run_word(38'h3, 27'd2, "three");
    run_word(38'h155, 27'd55, "odd_fibs");
    run_word(38'h20_0000_0000, 27'd39088169, "msb");
    run_word(38'h10_0000_0001, 27'd24157818, "b36_b0");
    run_word(38'h3F_FFFF_FFFF, 27'd102334154, "full");

    // Backpressure: result must hold while out_ready is low
    out_ready = 1'b0;
    run_word(38'h155, 27'd55, "bp");
    for (int i = 0; i < 50; i++) begin
      tick();
      check("bp_hold_data", data_out, 55);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_rdy", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", out_valid, 0);
    check("bp_release_rdy", in_ready, 1);
    check("bp_data_kept", data_out, 55);

    // Reset during ACC cycle 7 discards the word asynchronously
    code_in  = 38'h3F_FFFF_FFFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    check("pre_rst_busy", in_ready, 0);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_data", data_out, 0);
    #2 reset_n = 1'b1;
    tick();
    run_word(38'h7, 27'd4, "post_rst");

    // in_valid held across DONE->IDLE: next accept 21 edges later
    code_in  = 38'h1;
    in_valid = 1'b1;
    tick();
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 100) begin
      acc_now = in_ready && in_valid;
      tick();
      edges++;
      if (acc_now) seen = 1'b1;
    end
    in_valid = 1'b0;
    check("b2b_spacing", edges, 21);
    edges = 0;
    while (out_valid !== 1'b1 && edges < 100) begin
      tick();
      edges++;
    end
    check("b2b_lat", edges, 19);
    check("b2b_data", data_out, 1);
    tick();

    // BPC sweep
    sweep(38'h7, 27'd4, "sw_seven");
    sweep(38'h3F_FFFF_FFFF, 27'd102334154, "sw_full");
    sweep(38'h10_0000_0001, 27'd24157818, "sw_b36_b0");

`ifdef FPF_CHECK_EN
    run_word(38'b010, 27'd1, "err_word");
    check("err_flag", last_err, 1);
    run_word(38'h3, 27'd2, "legal_word");
    check("err_clear", last_err, 0);
`endif

    // Round trip through a greedy Fibonacci encoder
    for (int i = 0; i < 200; i++) begin
      v = $urandom_range(MAXV, 0);
      run_word(encode(v), v[26:0], "rt");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
